// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter/sequencer for a shared 2:1 mux, with registered data and valid flag.
// Optional grant locking (lock0/lock1 ports) is enabled by defining MUX_ARB_LOCK_EN.
module mux2_rr_arbiter #(
  parameter int WIDTH    = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] din0,
  input  logic [WIDTH-1:0] din1,
`ifdef MUX_ARB_LOCK_EN
  input  logic             lock0,
  input  logic             lock1,
`endif
  output logic             gnt0,
  output logic             gnt1,
  output logic             sel,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid
);

  localparam int CW = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] HOLD_MAX  = CW'(MAX_HOLD);
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t          state, state_next;
  logic            last, last_next;
  logic [CW-1:0]   hold_cnt, hold_next;
  logic            sel_next;
  logic            lock0_eff, lock1_eff;

`ifdef MUX_ARB_LOCK_EN
  assign lock0_eff = lock0;
  assign lock1_eff = lock1;
`else
  assign lock0_eff = 1'b0;
  assign lock1_eff = 1'b0;
`endif

  // Preemption uses >= so that a count saturated while the other side was idle
  // (or while locked) still hands over as soon as the other side asks.
  always_comb begin
    state_next = state;
    last_next  = last;
    hold_next  = hold_cnt;
    sel_next   = sel;
    case (state)
      IDLE: begin
        if (req0 && req1)  state_next = last ? GNT0 : GNT1;
        else if (req0)     state_next = GNT0;
        else if (req1)     state_next = GNT1;
      end
      GNT0: begin
        if (!req0)                                        state_next = req1 ? GNT1 : IDLE;
        else if (req1 && !lock0_eff && hold_cnt >= HOLD_LAST) state_next = GNT1;
      end
      GNT1: begin
        if (!req1)                                        state_next = req0 ? GNT0 : IDLE;
        else if (req0 && !lock1_eff && hold_cnt >= HOLD_LAST) state_next = GNT0;
      end
      default: state_next = IDLE;
    endcase

    if (state_next == GNT0 && state != GNT0) begin
      last_next = 1'b0;
      hold_next = '0;
      sel_next  = 1'b0;
    end else if (state_next == GNT1 && state != GNT1) begin
      last_next = 1'b1;
      hold_next = '0;
      sel_next  = 1'b1;
    end else if (state_next == IDLE) begin
      hold_next = '0;
    end else if (hold_cnt != HOLD_MAX) begin
      hold_next = hold_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last       <= 1'b1;
      hold_cnt   <= '0;
      sel        <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      state      <= state_next;
      last       <= last_next;
      hold_cnt   <= hold_next;
      sel        <= sel_next;
      dout_valid <= (state != IDLE);
      if (state != IDLE) dout <= sel ? din1 : din0;
    end
  end

  assign gnt0 = (state == GNT0);
  assign gnt1 = (state == GNT1);

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Self-checking bench for mux2_rr_arbiter: vector table, directed corner sequences,
// and randomized traffic against a grant-ownership model. Honours MUX_ARB_LOCK_EN.
module tb_mux2_rr_arbiter;

  localparam int WIDTH    = 1;
  localparam int MAX_HOLD = 4;

  logic             clk = 1'b0;
  logic             rst, req0, req1, lock0, lock1;
  logic [WIDTH-1:0] din0, din1;
  logic             gnt0, gnt1, sel, dout_valid;
  logic [WIDTH-1:0] dout;

  int checks = 0;
  int errors = 0;

  // Model: who owns the mux, how many visible cycles it has held it, and the data stage.
  int               mOwner = -1;
  int               mCount = 0;
  int               mLast  = 1;
  logic             mSel   = 1'b0;
  logic [WIDTH-1:0] mDout  = '0;
  logic             mValid = 1'b0;

  typedef struct {
    logic             rs, r0, r1;
    logic [WIDTH-1:0] d0, d1;
    logic             eg0, eg1, esel;
    logic [WIDTH-1:0] edout;
    logic             evalid;
  } vec_t;

  vec_t vecs [16];

  mux2_rr_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .din0(din0), .din1(din1),
`ifdef MUX_ARB_LOCK_EN
    .lock0(lock0), .lock1(lock1),
`endif
    .gnt0(gnt0), .gnt1(gnt1), .sel(sel), .dout(dout), .dout_valid(dout_valid)
  );

  always #5 clk = ~clk;

  // Drives one cycle of inputs, advances the model from the same inputs, samples #1 after the edge.
  task automatic applyStimulus(input logic rs, input logic r0, input logic r1,
                               input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1);
    int nOwner, nCount, nLast, me, other;
    logic nSel, nValid;
    logic [WIDTH-1:0] nDout;
    logic rq [2];
    logic lk [2];
    rst = rs; req0 = r0; req1 = r1; din0 = d0; din1 = d1;
    rq[0] = r0; rq[1] = r1;
`ifdef MUX_ARB_LOCK_EN
    lk[0] = lock0; lk[1] = lock1;
`else
    lk[0] = 1'b0; lk[1] = 1'b0;
`endif
    if (rs) begin
      nOwner = -1; nCount = 0; nLast = 1; nSel = 1'b0; nDout = '0; nValid = 1'b0;
    end else begin
      nDout  = mDout;
      nValid = (mOwner >= 0);
      if (mOwner >= 0) nDout = (mOwner == 1) ? d1 : d0;
      nOwner = mOwner;
      if (mOwner < 0) begin
        if (r0 && r1)  nOwner = 1 - mLast;
        else if (r0)   nOwner = 0;
        else if (r1)   nOwner = 1;
      end else begin
        me = mOwner; other = 1 - mOwner;
        if (!rq[me])                                         nOwner = rq[other] ? other : -1;
        else if (rq[other] && !lk[me] && mCount >= MAX_HOLD) nOwner = other;
      end
      nLast = mLast; nCount = mCount; nSel = mSel;
      if (nOwner < 0) nCount = 0;
      else if (nOwner != mOwner) begin nCount = 1; nLast = nOwner; end
      else nCount = mCount + 1;
      if (nOwner >= 0) nSel = (nOwner == 1);
    end
    @(posedge clk);
    #1;
    mOwner = nOwner; mCount = nCount; mLast = nLast; mSel = nSel; mDout = nDout; mValid = nValid;
  endtask

  task automatic checkOutput(input string name, input logic eg0, input logic eg1, input logic esel,
                             input logic [WIDTH-1:0] edout, input logic evalid);
    checks++;
    if ({gnt0, gnt1, sel, dout, dout_valid} !== {eg0, eg1, esel, edout, evalid}) begin
      errors++;
      $display("[TB] FAIL %s: got gnt0=%b gnt1=%b sel=%b dout=%h valid=%b, expected gnt0=%b gnt1=%b sel=%b dout=%h valid=%b",
               name, gnt0, gnt1, sel, dout, dout_valid, eg0, eg1, esel, edout, evalid);
    end
  endtask

  task automatic checkGrant(input string name, input logic eg0, input logic eg1, input logic esel);
    checks++;
    if ({gnt0, gnt1, sel} !== {eg0, eg1, esel}) begin
      errors++;
      $display("[TB] FAIL %s: got gnt0=%b gnt1=%b sel=%b, expected gnt0=%b gnt1=%b sel=%b",
               name, gnt0, gnt1, sel, eg0, eg1, esel);
    end
  endtask

  task automatic checkData(input string name, input logic [WIDTH-1:0] edout, input logic evalid);
    checks++;
    if ({dout, dout_valid} !== {edout, evalid}) begin
      errors++;
      $display("[TB] FAIL %s: got dout=%h valid=%b, expected dout=%h valid=%b",
               name, dout, dout_valid, edout, evalid);
    end
  endtask

  initial begin
    lock0 = 1'b0; lock1 = 1'b0;

    //            rs    r0    r1    d0    d1    g0    g1    sel   dout  valid
    vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[15] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].rs, vecs[i].r0, vecs[i].r1, vecs[i].d0, vecs[i].d1);
      checkOutput($sformatf("vec%0d", i), vecs[i].eg0, vecs[i].eg1, vecs[i].esel,
                  vecs[i].edout, vecs[i].evalid);
    end

    // Lone requester keeps the grant; once saturated, a new contender takes over at once.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      checkGrant($sformatf("single_gnt%0d", i), 1'b0, 1'b1, 1'b1);
      if (i >= 1) checkData($sformatf("single_data%0d", i), 1'b1, 1'b1);
      else        checkData("single_data0", 1'b0, 1'b0);
    end
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    checkGrant("saturated_preempt", 1'b1, 1'b0, 1'b0);

    // Reset in the middle of a GNT1 burst, then the first tie goes to requester 0.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    checkGrant("pre_reset_gnt1", 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("mid_reset", 1'b0, 1'b0, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    checkGrant("post_reset_tie", 1'b1, 1'b0, 1'b0);

`ifdef MUX_ARB_LOCK_EN
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    lock0 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      checkGrant($sformatf("lock_hold%0d", i), 1'b1, 1'b0, 1'b0);
    end
    lock0 = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    checkGrant("lock_release", 1'b0, 1'b1, 1'b1);
`endif

    // Random traffic with sticky-ish requests and rare resets, compared to the model.
    for (int i = 0; i < 2000; i++) begin
`ifdef MUX_ARB_LOCK_EN
      lock0 = ($urandom_range(7, 0) == 0);
      lock1 = ($urandom_range(7, 0) == 0);
`endif
      applyStimulus(($urandom_range(49, 0) == 0),
                    ($urandom_range(3, 0) != 0), ($urandom_range(3, 0) != 0),
                    WIDTH'($urandom), WIDTH'($urandom));
      checkOutput($sformatf("random%0d", i), (mOwner == 0), (mOwner == 1), mSel, mDout, mValid);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
